// File: rtl/breadboard_sweep_ctrl.sv
// Sweep controller for a 4-input breadboard function unit: applies a range of
// input vectors, waits a settle time, and hands each captured result to a consumer.
module breadboard_sweep_ctrl #(
  parameter int unsigned SETTLE = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [3:0]  first,
  input  logic [3:0]  last,
  output logic [3:0]  fu_in,
  input  logic [9:0]  fu_out,
  output logic        busy,
  output logic        done,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [3:0]  res_idx,
  output logic [9:0]  res_data,
  output logic [4:0]  count,
  output logic [15:0] sig
);

  // state | meaning
  // IDLE  | waiting for start; fu_in holds last vector
  // APPLY | fu_in driven with idx, settle timer counting down
  // OUT   | captured result offered on res_*, waiting for handshake
  // DONE  | one-cycle completion pulse
  typedef enum logic [1:0] {IDLE, APPLY, OUT, DONE} state_t;

  localparam logic [3:0] SETTLE_LD = 4'(SETTLE - 1);

  state_t     state, state_nxt;
  logic [3:0] idx;
  logic [3:0] last_q;
  logic [3:0] settle_cnt;
  logic [3:0] idx_inc;
  logic       do_start;
  logic       do_capture;
  logic       do_accept;
  logic       at_last;

  assign idx_inc = idx + 4'd1;
  assign at_last = (idx == last_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // abort suppresses every strobe, so it wins over a same-cycle handshake
  always_comb begin
    state_nxt  = state;
    do_start   = 1'b0;
    do_capture = 1'b0;
    do_accept  = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          do_start  = 1'b1;
          state_nxt = APPLY;
        end
      end
      APPLY: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (settle_cnt == 4'd0) begin
          do_capture = 1'b1;
          state_nxt  = OUT;
        end
      end
      OUT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (res_ready) begin
          do_accept = 1'b1;
          state_nxt = at_last ? DONE : APPLY;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign busy      = (state == APPLY) || (state == OUT);
  assign res_valid = (state == OUT);
  assign done      = (state == DONE) && !abort;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx        <= 4'd0;
      last_q     <= 4'd0;
      fu_in      <= 4'd0;
      settle_cnt <= 4'd0;
      res_idx    <= 4'd0;
      res_data   <= 10'd0;
      count      <= 5'd0;
      sig        <= 16'd0;
    end else begin
      if (do_start) begin
        idx        <= first;
        last_q     <= last;
        fu_in      <= first;
        settle_cnt <= SETTLE_LD;
        count      <= 5'd0;
        sig        <= 16'd0;
      end else if (do_accept) begin
        count <= count + 5'd1;
        sig   <= {sig[14:0], sig[15]} ^ {6'b0, res_data};
        if (!at_last) begin
          idx        <= idx_inc;
          fu_in      <= idx_inc;
          settle_cnt <= SETTLE_LD;
        end
      end else if (state == APPLY && settle_cnt != 4'd0 && !abort) begin
        settle_cnt <= settle_cnt - 4'd1;
      end
      if (do_capture) begin
        res_data <= fu_out;
        res_idx  <= idx;
      end
    end
  end

endmodule

// File: tb/tb_breadboard_sweep_ctrl.sv
// Directed bench for breadboard_sweep_ctrl with a behavioural function unit
// and hand-derived expectations for latency, ordering, signature and abort/reset.
module tb_breadboard_sweep_ctrl;
  localparam int SETTLE = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, abort, res_ready;
  logic [3:0]  first, last, fu_in, res_idx;
  logic [9:0]  fu_out, res_data;
  logic        busy, done, res_valid;
  logic [4:0]  count;
  logic [15:0] sig;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  function automatic logic [9:0] fu_model(input logic [3:0] v);
    return 10'h194 ^ {v, v, 2'b00};
  endfunction

  function automatic logic [15:0] sig_step(input logic [15:0] s, input logic [9:0] d);
    return {s[14:0], s[15]} ^ {6'b0, d};
  endfunction

  assign fu_out = fu_model(fu_in);

  breadboard_sweep_ctrl #(.SETTLE(SETTLE)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .first(first), .last(last), .fu_in(fu_in), .fu_out(fu_out),
    .busy(busy), .done(done), .res_valid(res_valid), .res_ready(res_ready),
    .res_idx(res_idx), .res_data(res_data), .count(count), .sig(sig)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic run_sweep(input logic [3:0] f, input logic [3:0] l);
    logic [3:0]  exp_idx;
    logic [15:0] sig_m;
    int          nres, lat, nv;
    bit          seen;
    nv = int'(4'(l - f)) + 1;
    @(negedge clk);
    first = f; last = l; start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp_idx = f; sig_m = 16'd0; nres = 0; lat = 0; seen = 1'b0;
    for (int c = 1; c <= 300 && !seen; c++) begin
      if (res_valid) begin
        chk($sformatf("res_idx[%0d]", nres), 32'(res_idx), 32'(exp_idx));
        chk($sformatf("res_data[%0d]", nres), 32'(res_data), 32'(fu_model(exp_idx)));
        sig_m = sig_step(sig_m, fu_model(exp_idx));
        exp_idx = exp_idx + 4'd1;
        nres++;
      end
      if (done) begin
        seen = 1'b1;
        lat = c;
      end else begin
        @(negedge clk);
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("latency", 32'(lat), 32'(nv * (SETTLE + 1) + 1));
    chk("n_results", 32'(nres), 32'(nv));
    chk("count", 32'(count), 32'(nv));
    chk("sig", 32'(sig), 32'(sig_m));
    chk("busy_in_done", 32'(busy), 32'd0);
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
  endtask

  initial begin
    logic [15:0] sig_m;
    bit          bad;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; res_ready = 1'b0;
    first = 4'd0; last = 4'd0;
    #12;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_valid", 32'(res_valid), 32'd0);
    chk("rst_outs", {fu_in, res_idx, res_data, count, done, 8'd0}, 32'd0);
    chk("rst_sig", 32'(sig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // single vector: 0x194, sig 0x0194, latency 4
    run_sweep(4'd0, 4'd0);
    chk("single_sig", 32'(sig), 32'h0194);
    chk("single_data", 32'(res_data), 32'h194);

    run_sweep(4'd0, 4'd15);
    run_sweep(4'd14, 4'd1);
    run_sweep(4'd7, 4'd9);

    // abort with start in IDLE must not start
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("abort_start_idle", 32'(busy), 32'd0);

    // backpressure
    @(negedge clk);
    first = 4'd5; last = 4'd5; start = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && !res_valid; c++) @(negedge clk);
    chk("bp_valid", 32'(res_valid), 32'd1);
    bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (!res_valid || res_data !== fu_model(4'd5) || fu_in !== 4'd5 ||
          res_idx !== 4'd5 || count !== 5'd0 || done) bad = 1'b1;
      if (c < 4) @(negedge clk);
    end
    chk("bp_stable", 32'(bad), 32'd0);
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_count", 32'(count), 32'd1);
    chk("bp_done", 32'(done), 32'd1);
    chk("bp_fu_hold_done", 32'(fu_in), 32'd5);
    @(negedge clk);
    chk("bp_fu_hold_idle", 32'(fu_in), 32'd5);

    // abort in third OUT
    first = 4'd0; last = 4'd15; start = 1'b1; res_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    begin
      int nout;
      nout = 0;
      for (int c = 0; c < 100 && nout < 3; c++) begin
        if (res_valid) nout++;
        if (nout < 3) @(negedge clk);
      end
      chk("abort_reached", 32'(nout), 32'd3);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    sig_m = sig_step(sig_step(16'd0, fu_model(4'd0)), fu_model(4'd1));
    chk("abort_valid", 32'(res_valid), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_count", 32'(count), 32'd2);
    chk("abort_sig", 32'(sig), 32'(sig_m));
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy) bad = 1'b1;
      @(negedge clk);
    end
    chk("abort_no_done", 32'(bad), 32'd0);

    // reset during APPLY
    first = 4'd0; last = 4'd15; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_outs", {fu_in, res_idx, res_data, count, done, res_valid, 7'd0}, 32'd0);
    chk("arst_sig", 32'(sig), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 6; c++) begin
      if (done || busy) bad = 1'b1;
      @(negedge clk);
    end
    chk("rst_no_done", 32'(bad), 32'd0);
    run_sweep(4'd3, 4'd3);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
endmodule
